junction_scheduler: RTL



---
 rtl/junction_pkg.sv | 16 +
 rtl/junction_rr_pick.sv | 31 +++
 rtl/junction_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/junction_pkg.sv
// junction_pkg: shared definitions for the junction scheduler.
//   phase_e : phase encoding (2'd3 is unused and treated as all-red)
//   idx_w() : index width for an N-entry approach vector
package junction_pkg;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_AMBER  = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/junction_rr_pick.sv
// rr_pick: combinational round-robin finder.
//   req   : request vector
//   base  : index of the current owner; search starts at base+1
//   found : some req bit is set
//   idx   : first set bit at base+1, base+2, ... (mod N), base itself last
module rr_pick
  import junction_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // Walk farthest-to-nearest so the nearest hit is written last and wins.
  always_comb begin
    found = |req;
    idx   = base;
    j     = base;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(base) + k) % N);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/junction_scheduler.sv
// junction_scheduler: round-robin junction controller.
//   clk, rst        : clock, synchronous active-high reset
//   tick            : one-cycle timebase strobe, advances the phase counter
//   sensor, button  : per-approach vehicle presence / demand request
//   red/amber/green : registered one-hot lamp drives per approach
//   cur_idx         : approach currently owning the junction
//   phase           : GREEN / AMBER / ALLRED
module junction_scheduler
  import junction_pkg::*;
#(
  parameter int N_APPROACH   = 4,
  parameter int GREEN_MIN    = 4,
  parameter int GREEN_MAX    = 8,
  parameter int AMBER_TICKS  = 2,
  parameter int ALLRED_TICKS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [N_APPROACH-1:0]         sensor,
  input  logic [N_APPROACH-1:0]         button,
  output logic [N_APPROACH-1:0]         red,
  output logic [N_APPROACH-1:0]         amber,
  output logic [N_APPROACH-1:0]         green,
  output logic [$clog2(N_APPROACH)-1:0] cur_idx,
  output logic [1:0]                    phase
);

  localparam int N  = N_APPROACH;
  localparam int IW = idx_w(N);
  localparam int CW = $clog2(GREEN_MAX + 1);
  localparam logic [CW-1:0] G_MIN = CW'(GREEN_MIN);
  localparam logic [CW-1:0] G_MAX = CW'(GREEN_MAX);
  localparam logic [CW-1:0] A_T   = CW'(AMBER_TICKS);
  localparam logic [CW-1:0] R_T   = CW'(ALLRED_TICKS);
  localparam logic [N-1:0]  LAMP0 = N'(1);

  phase_e        ph, ph_nxt;
  logic [IW-1:0] cur, cur_nxt, nxt_idx, nxt_nxt, pick;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  pend, pend_nxt, cur_oh, req_oth, green_d, amber_d;
  logic          other;

  // Search excludes the owner so "someone else is waiting" is just found.
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req_oth),
    .base (cur),
    .found(other),
    .idx  (pick)
  );

  always_comb begin
    cur_oh      = '0;
    cur_oh[cur] = 1'b1;
    req_oth     = pend & ~cur_oh;
  end

  always_comb begin
    ph_nxt  = ph;
    cur_nxt = cur;
    nxt_nxt = nxt_idx;
    case (ph)
      PH_GREEN:
        if (cnt >= G_MIN && other && (!sensor[cur] || cnt >= G_MAX)) begin
          ph_nxt  = PH_AMBER;
          nxt_nxt = pick;
        end
      PH_AMBER:
        if (cnt >= A_T) ph_nxt = PH_ALLRED;
      default:
        if (cnt >= R_T) begin
          ph_nxt  = PH_GREEN;
          cur_nxt = nxt_idx;
        end
    endcase

    // Owner's own demand is meaningless while it already holds green.
    pend_nxt = pend | ((sensor | button) & ~((ph == PH_GREEN) ? cur_oh : '0));
    if (ph != PH_GREEN && ph != PH_AMBER && ph_nxt == PH_GREEN)
      pend_nxt[nxt_idx] = 1'b0;

    if (ph_nxt != ph)           cnt_nxt = '0;
    else if (tick && cnt != G_MAX) cnt_nxt = cnt + 1'b1;
    else                        cnt_nxt = cnt;

    // Lamps decode from next state so they move on the same edge as phase.
    green_d = '0;
    amber_d = '0;
    if (ph_nxt == PH_GREEN)      green_d[cur_nxt] = 1'b1;
    else if (ph_nxt == PH_AMBER) amber_d[cur_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph      <= PH_GREEN;
      cur     <= '0;
      nxt_idx <= '0;
      cnt     <= '0;
      pend    <= '0;
      green   <= LAMP0;
      amber   <= '0;
      red     <= ~LAMP0;
    end else begin
      ph      <= ph_nxt;
      cur     <= cur_nxt;
      nxt_idx <= nxt_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      green   <= green_d;
      amber   <= amber_d;
      red     <= ~(green_d | amber_d);
    end
  end

  assign cur_idx = cur;
  assign phase   = ph;

endmodule
